// File: rtl/score_bcd_accum_if.sv
// Add-request handshake between a score source and score_bcd_accum.
// master drives the request; slave (the accumulator) returns add_ready.
interface score_bcd_accum_if;
  logic       add_valid;
  logic [3:0] add_amt;
  logic       add_ready;

  modport master (output add_valid, output add_amt, input add_ready);
  modport slave  (input add_valid, input add_amt, output add_ready);
endinterface

// File: rtl/score_bcd_accum.sv
// Four-digit BCD score accumulator: one digit per cycle, committed all at once, saturating at 9999.
// Optional macro SCORE_LEADING_ZERO_BLANK_EN enables leading-zero blanking on blank_o.
module score_bcd_accum (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear_i,
  score_bcd_accum_if.slave        add_if,
  output logic                    done_o,
  output logic                    sat_o,
  output logic [3:0]              digit0_o,
  output logic [3:0]              digit1_o,
  output logic [3:0]              digit2_o,
  output logic [3:0]              digit3_o,
  output logic [3:0]              blank_o
);

  localparam int unsigned DigitW = 4;
  localparam int unsigned NumDig = 4;
  localparam int unsigned SumW   = DigitW + 1;

  typedef enum logic [1:0] {IDLE, ADD, COMMIT} state_e;

  state_e                           state_q;
  logic [1:0]                       idx_q;
  logic [DigitW-1:0]                amt_q;
  logic [NumDig-1:0][DigitW-1:0]    work_q;
  logic [NumDig-1:0][DigitW-1:0]    score_q;
  logic                             carry_q;
  logic                             done_q;
  logic                             sat_q;
  logic                             ready_q;

  logic [DigitW-1:0]                operand_c;
  logic [SumW-1:0]                  digit_sum_c;
  logic [DigitW-1:0]                digit_d;
  logic                             carry_d;
  logic [DigitW-1:0]                amt_clamped_c;

  // Single-digit BCD adder for the digit currently selected by idx_q.
  always_comb begin
    operand_c   = (idx_q == 2'd0) ? amt_q : '0;
    digit_sum_c = SumW'(work_q[idx_q]) + SumW'(operand_c) + SumW'(carry_q);
    digit_d     = DigitW'(digit_sum_c);
    carry_d     = 1'b0;
    if (digit_sum_c > SumW'(9)) begin
      digit_d = DigitW'(digit_sum_c - SumW'(10));
      carry_d = 1'b1;
    end
  end

  assign amt_clamped_c = (add_if.add_amt > DigitW'(9)) ? DigitW'(9) : add_if.add_amt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      amt_q   <= '0;
      work_q  <= '0;
      score_q <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
      sat_q   <= 1'b0;
      ready_q <= 1'b1;
    end else if (clear_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      work_q  <= '0;
      score_q <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
      sat_q   <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (add_if.add_valid) begin
            state_q <= ADD;
            ready_q <= 1'b0;
            idx_q   <= '0;
            amt_q   <= amt_clamped_c;
            work_q  <= score_q;
            carry_q <= 1'b0;
          end
        end
        ADD: begin
          work_q[idx_q] <= digit_d;
          carry_q       <= carry_d;
          idx_q         <= idx_q + 2'd1;
          if (idx_q == 2'd3) state_q <= COMMIT;
        end
        COMMIT: begin
          // A carry out of the thousands digit pins the score at 9999.
          if (carry_q) begin
            score_q <= {NumDig{DigitW'(9)}};
            sat_q   <= 1'b1;
          end else begin
            score_q <= work_q;
          end
          done_q  <= 1'b1;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign add_if.add_ready = ready_q;
  assign done_o           = done_q;
  assign sat_o            = sat_q;
  assign digit0_o         = score_q[0];
  assign digit1_o         = score_q[1];
  assign digit2_o         = score_q[2];
  assign digit3_o         = score_q[3];

`ifdef SCORE_LEADING_ZERO_BLANK_EN
  // A digit blanks only when it and every higher digit are zero; ones never blank.
  logic [3:0] blank_c;
  always_comb begin
    blank_c    = '0;
    blank_c[3] = (score_q[3] == '0);
    blank_c[2] = blank_c[3] && (score_q[2] == '0);
    blank_c[1] = blank_c[2] && (score_q[1] == '0);
  end
  assign blank_o = blank_c;
`else
  assign blank_o = 4'b0000;
`endif

endmodule

// File: tb/tb_score_bcd_accum.sv
// Directed bench for score_bcd_accum: reset, adds, ripple carry, saturation, clear and reset aborts.
module tb_score_bcd_accum;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       done;
  logic       sat;
  logic [3:0] d0, d1, d2, d3;
  logic [3:0] blank;

  int checks;
  int errors;
  int model_score;
  bit model_sat;

`ifdef SCORE_LEADING_ZERO_BLANK_EN
  localparam logic [3:0] BlankZero = 4'b1110;
  localparam logic [3:0] Blank12   = 4'b1100;
`else
  localparam logic [3:0] BlankZero = 4'b0000;
  localparam logic [3:0] Blank12   = 4'b0000;
`endif

  score_bcd_accum_if bus ();

  score_bcd_accum dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (clear),
    .add_if   (bus.slave),
    .done_o   (done),
    .sat_o    (sat),
    .digit0_o (d0),
    .digit1_o (d1),
    .digit2_o (d2),
    .digit3_o (d3),
    .blank_o  (blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] score_w;
  assign score_w = {d3, d2, d1, d0};

  function automatic logic [15:0] to_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One add transaction: digits must hold for the accept edge plus four ADD edges, then all change together with done.
  task automatic do_add(input logic [3:0] amt);
    logic [15:0] old_bcd;
    int a;
    old_bcd = to_bcd(model_score);
    a = (amt > 4'd9) ? 9 : int'(amt);
    model_score = model_score + a;
    if (model_score > 9999) begin
      model_score = 9999;
      model_sat   = 1'b1;
    end
    check("ready_pre", 32'(bus.add_ready), 32'd1);
    bus.add_valid = 1'b1;
    bus.add_amt   = amt;
    for (int k = 0; k < 5; k++) begin
      step();
      bus.add_valid = 1'b0;
      bus.add_amt   = 4'd0;
      check("busy_ready", 32'(bus.add_ready), 32'd0);
      check("hold_done", 32'(done), 32'd0);
      check("hold_score", 32'(score_w), 32'(old_bcd));
    end
    step();
    check("done_pulse", 32'(done), 32'd1);
    check("commit_score", 32'(score_w), 32'(to_bcd(model_score)));
    check("commit_ready", 32'(bus.add_ready), 32'd1);
    check("commit_sat", 32'(sat), 32'(model_sat));
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    model_score = 0;
    model_sat   = 1'b0;
    check("clr_score", 32'(score_w), 32'h0);
    check("clr_sat", 32'(sat), 32'd0);
    check("clr_ready", 32'(bus.add_ready), 32'd1);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    model_score   = 0;
    model_sat     = 1'b0;
    rst_n         = 1'b0;
    clear         = 1'b0;
    bus.add_valid = 1'b0;
    bus.add_amt   = 4'd0;

    step();
    step();
    rst_n = 1'b1;
    check("rst_score", 32'(score_w), 32'h0);
    check("rst_sat", 32'(sat), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(bus.add_ready), 32'd1);
    check("rst_blank", 32'(blank), 32'(BlankZero));

    do_add(4'd7);
    check("score_7", 32'(score_w), 32'h0007);
    do_add(4'd5);
    check("score_12", 32'(score_w), 32'h0012);
    check("blank_12", 32'(blank), 32'(Blank12));
    do_add(4'd0);
    check("score_add0", 32'(score_w), 32'h0012);

    // Clear has priority over a simultaneous add request in IDLE.
    clear = 1'b1;
    bus.add_valid = 1'b1;
    bus.add_amt = 4'd3;
    step();
    clear = 1'b0;
    bus.add_valid = 1'b0;
    model_score = 0;
    check("clr_prio_ready", 32'(bus.add_ready), 32'd1);
    check("clr_prio_score", 32'(score_w), 32'h0);

    for (int i = 0; i < 111; i++) do_add(4'd9);
    check("score_999", 32'(score_w), 32'h0999);
    do_add(4'd1);
    check("score_1000", 32'(score_w), 32'h1000);
    check("blank_1000", 32'(blank), 32'h0);

    do_clear();
    for (int i = 0; i < 1110; i++) do_add(4'd9);
    do_add(4'd5);
    check("score_9995", 32'(score_w), 32'h9995);
    check("sat_9995", 32'(sat), 32'd0);
    do_add(4'd9);
    check("score_sat", 32'(score_w), 32'h9999);
    check("sat_set", 32'(sat), 32'd1);
    do_add(4'd3);
    check("score_sat2", 32'(score_w), 32'h9999);
    check("sat_sticky", 32'(sat), 32'd1);
    do_add(4'hC);
    check("score_sat3", 32'(score_w), 32'h9999);

    // Clear two cycles after acceptance, with add_valid also high.
    bus.add_valid = 1'b1;
    bus.add_amt = 4'd4;
    step();
    bus.add_valid = 1'b0;
    step();
    clear = 1'b1;
    bus.add_valid = 1'b1;
    step();
    clear = 1'b0;
    bus.add_valid = 1'b0;
    model_score = 0;
    model_sat = 1'b0;
    check("abort_score", 32'(score_w), 32'h0);
    check("abort_sat", 32'(sat), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_ready", 32'(bus.add_ready), 32'd1);
    for (int k = 0; k < 6; k++) begin
      step();
      check("abort_no_done", 32'(done), 32'd0);
      check("abort_hold", 32'(score_w), 32'h0);
    end

    // Reset in the cycle after acceptance drops the add.
    bus.add_valid = 1'b1;
    bus.add_amt = 4'd9;
    step();
    bus.add_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rabort_score", 32'(score_w), 32'h0);
    check("rabort_ready", 32'(bus.add_ready), 32'd1);
    check("rabort_done", 32'(done), 32'd0);
    for (int k = 0; k < 6; k++) begin
      step();
      check("rabort_no_done", 32'(done), 32'd0);
      check("rabort_hold", 32'(score_w), 32'h0);
    end
    do_add(4'hF);
    check("clamp_score", 32'(score_w), 32'h0009);
    check("blank_9", 32'(blank), 32'(BlankZero));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
